// File: rtl/pooling_engine.sv
// Streaming KxK non-overlapping max/average pooling over a raster-ordered
// feature map, CH channels in lockstep, with valid/ready on both sides.
module pooling_engine #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CH     = 32,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned POOL_K = 2
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     start,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data [CH],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data [CH],
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned LK    = $clog2(POOL_K);
    localparam int unsigned SH    = 2 * LK;
    localparam int unsigned ACC_W = DATA_W + SH;
    localparam int unsigned OUT_W = IMG_W / POOL_K;
    localparam int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned WXW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                    state;
    logic [CW-1:0]             col;
    logic [RW-1:0]             row;
    logic                      mode_q;
    logic signed [ACC_W-1:0]   acc [CH][OUT_W];

    logic [LK-1:0]             kx;
    logic [LK-1:0]             ky;
    logic [WXW-1:0]            wx;
    logic                      beat;
    logic                      win_first;
    logic                      win_last;
    logic                      frame_last;

    logic signed [ACC_W-1:0]   xe  [CH];
    logic signed [ACC_W-1:0]   cur [CH];
    logic signed [ACC_W-1:0]   sum [CH];
    logic signed [ACC_W-1:0]   mx  [CH];
    logic signed [DATA_W-1:0]  res [CH];

    // A held result blocks every input beat, not only window-completing ones.
    assign in_ready   = (state == RUN) && (!out_valid || out_ready);
    assign beat       = in_valid && in_ready;
    assign done       = (state == DRAIN) && out_valid && out_ready;

    assign kx         = col[LK-1:0];
    assign ky         = row[LK-1:0];
    assign wx         = WXW'(col >> LK);
    assign win_first  = (kx == '0) && (ky == '0);
    assign win_last   = (kx == LK'(POOL_K - 1)) && (ky == LK'(POOL_K - 1));
    assign frame_last = (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1));

    // Per-channel window update and the finished result when this beat closes it.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            xe[c]  = {{SH{in_data[c][DATA_W-1]}}, in_data[c]};
            cur[c] = acc[c][wx];
            sum[c] = cur[c] + xe[c];
            mx[c]  = (xe[c] > cur[c]) ? xe[c] : cur[c];
            res[c] = mode_q ? DATA_W'(sum[c] >>> SH) : DATA_W'(mx[c]);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            mode_q    <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                out_data[c] <= '0;
                for (int w = 0; w < OUT_W; w++) acc[c][w] <= '0;
            end
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        col    <= '0;
                        row    <= '0;
                        mode_q <= mode;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (beat && frame_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (beat) begin
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end

                for (int c = 0; c < CH; c++) begin
                    if (win_first)   acc[c][wx] <= xe[c];
                    else if (mode_q) acc[c][wx] <= sum[c];
                    else             acc[c][wx] <= mx[c];
                end

                // Loading here while the old result leaves gives one result per beat.
                if (win_last) begin
                    out_valid <= 1'b1;
                    for (int c = 0; c < CH; c++) out_data[c] <= res[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_pooling_engine.sv
// Bench for pooling_engine on a 4x4, 2-channel, 2x2 configuration: frame
// table with known pooled values, scoreboard queue, and corner sequences.
module tb_pooling_engine;

    localparam int unsigned DW   = 16;
    localparam int unsigned NCH  = 2;
    localparam int unsigned IW   = 4;
    localparam int unsigned IH   = 4;
    localparam int unsigned K    = 2;
    localparam int unsigned NPIX = IW * IH;
    localparam int unsigned NWIN = (IW / K) * (IH / K);
    localparam int unsigned NF   = 4;

    logic clk = 1'b0;
    logic nrst;
    logic start;
    logic mode;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic busy;
    logic done;
    logic signed [DW-1:0] in_data  [NCH];
    logic signed [DW-1:0] out_data [NCH];

    always #5 clk = ~clk;

    pooling_engine #(
        .DATA_W(DW), .CH(NCH), .IMG_W(IW), .IMG_H(IH), .POOL_K(K)
    ) dut (
        .clk(clk), .nrst(nrst), .start(start), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic                     mode;
        logic [NPIX-1:0][DW-1:0]  px0;
        logic [NPIX-1:0][DW-1:0]  px1;
        logic [NWIN-1:0][DW-1:0]  ex0;
        logic [NWIN-1:0][DW-1:0]  ex1;
    } frame_t;

    typedef struct packed {
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } exp_t;

    frame_t frames [NF];
    exp_t   sbq [$];
    int     checks   = 0;
    int     passes   = 0;
    int     done_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic set_frame(input int fi, input logic m,
                             input int p0 [NPIX], input int p1 [NPIX],
                             input int e0 [NWIN], input int e1 [NWIN]);
        frames[fi].mode = m;
        for (int i = 0; i < NPIX; i++) begin
            frames[fi].px0[i] = DW'(p0[i]);
            frames[fi].px1[i] = DW'(p1[i]);
        end
        for (int w = 0; w < NWIN; w++) begin
            frames[fi].ex0[w] = DW'(e0[w]);
            frames[fi].ex1[w] = DW'(e1[w]);
        end
    endtask

    // Scoreboard: every accepted result is popped and compared.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (nrst && done) done_cnt++;
        if (nrst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("res_ch0", int'(out_data[0]), int'($signed(e.e0)));
                chk("res_ch1", int'(out_data[1]), int'($signed(e.e1)));
            end
        end
    end

    task automatic drive_frame(input int fi, input int inj_at, input int rst_after);
        int   k;
        int   stall;
        int   r;
        int   c;
        bit   took;
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1;
        mode  = frames[fi].mode;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = ~frames[fi].mode;
        chk("busy_rise", int'(busy), 1);
        k = 0;
        stall = 0;
        while (k < NPIX) begin
            in_valid   = 1'b1;
            in_data[0] = frames[fi].px0[k];
            in_data[1] = frames[fi].px1[k];
            if (k == inj_at) start = 1'b1;
            @(negedge clk);
            took = in_ready;
            if (took) begin
                r = k / IW;
                c = k % IW;
                if ((r % K == K - 1) && (c % K == K - 1)) begin
                    e.e0 = frames[fi].ex0[(r / K) * (IW / K) + c / K];
                    e.e1 = frames[fi].ex1[(r / K) * (IW / K) + c / K];
                    sbq.push_back(e);
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (took) begin
                k++;
                stall = 0;
            end else begin
                stall++;
                if (stall > 100) begin
                    chk("beat_timeout", k, NPIX);
                    break;
                end
            end
            if (k == rst_after) begin
                nrst = 1'b0;
                #1;
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_in_ready", int'(in_ready), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_out_data0", int'(out_data[0]), 0);
                chk("rst_out_data1", int'(out_data[1]), 0);
                sbq.delete();
                in_valid = 1'b0;
                @(posedge clk); #1;
                nrst = 1'b1;
                @(posedge clk); #1;
                chk("idle_in_ready", int'(in_ready), 0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_frame(input int dc0);
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (done_cnt > dc0) break;
        end
        chk("busy_fall", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_cnt - dc0, 1);
        chk("sb_empty", sbq.size(), 0);
    endtask

    // Holds the first result for 5 cycles, then releases the output side.
    task automatic bp_ctrl();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_seen", int'(seen), 1);
        for (int n = 0; n < 5; n++) begin
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_data", int'(out_data[0]), 5);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    initial begin
        int p0 [NPIX];
        int p1 [NPIX];
        int e0 [NWIN];
        int e1 [NWIN];
        int dc;

        for (int i = 0; i < NPIX; i++) begin
            p0[i] = i;
            p1[i] = -i;
        end
        e0 = '{5, 7, 13, 15};
        e1 = '{0, -2, -8, -10};
        set_frame(0, 1'b0, p0, p1, e0, e1);
        e0 = '{2, 4, 10, 12};
        e1 = '{-3, -5, -11, -13};
        set_frame(1, 1'b1, p0, p1, e0, e1);
        p0 = '{-1, -1, 32767, 32767, -1, -2, 32767, 32767,
               -32768, -32768, 7, 0, -32768, -32768, 0, 0};
        for (int i = 0; i < NPIX; i++) p1[i] = 3;
        e0 = '{-2, 32767, -32768, 1};
        e1 = '{3, 3, 3, 3};
        set_frame(2, 1'b1, p0, p1, e0, e1);
        p0 = '{-3, -7, -32768, -32768, -1, -8, -32768, -32768,
               32767, 0, -5, -5, 0, 0, -5, -5};
        for (int i = 0; i < NPIX; i++) p1[i] = 3 * i - 20;
        e0 = '{-1, -32768, 32767, -5};
        e1 = '{-5, 1, 19, 25};
        set_frame(3, 1'b0, p0, p1, e0, e1);

        nrst       = 1'b0;
        start      = 1'b0;
        mode       = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in_data[0] = '0;
        in_data[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_out_data0", int'(out_data[0]), 0);
        chk("reset_out_data1", int'(out_data[1]), 0);
        nrst = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_start", int'(in_ready), 0);

        for (int fi = 0; fi < NF; fi++) begin
            dc = done_cnt;
            drive_frame(fi, -1, -1);
            finish_frame(dc);
        end

        dc = done_cnt;
        out_ready = 1'b0;
        fork
            drive_frame(0, -1, -1);
            bp_ctrl();
        join
        finish_frame(dc);

        dc = done_cnt;
        drive_frame(0, 3, -1);
        finish_frame(dc);
        dc = done_cnt;
        drive_frame(1, -1, -1);
        finish_frame(dc);

        drive_frame(1, -1, 6);
        dc = done_cnt;
        drive_frame(1, -1, -1);
        finish_frame(dc);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
